// File: rtl/fifo_rd_packer_if.sv
// Bus bundle for fifo_rd_packer: the async-FIFO read port, the flush request
// and the packed valid/ready output stream.
interface fifo_rd_packer_if #(
    parameter int DATA_WIDTH = 8,
    parameter int PACK       = 4
);
    logic                       fifo_empty;
    logic                       fifo_r_en;
    logic [DATA_WIDTH-1:0]      fifo_data;
    logic                       flush;
    logic [DATA_WIDTH*PACK-1:0] m_data;
    logic [PACK-1:0]            m_keep;
    logic                       m_last;
    logic                       m_valid;
    logic                       m_ready;

    modport master (
        input  fifo_empty, fifo_data, flush, m_ready,
        output fifo_r_en, m_data, m_keep, m_last, m_valid
    );

    modport slave (
        output fifo_empty, fifo_data, flush, m_ready,
        input  fifo_r_en, m_data, m_keep, m_last, m_valid
    );
endinterface

// File: rtl/fifo_rd_packer.sv
// Read-domain drain engine: pops the async FIFO (1-cycle read latency), packs
// PACK lanes per word and emits words, or flushed partial words, on a valid/ready stream.
module fifo_rd_packer #(
    parameter int DATA_WIDTH = 8,
    parameter int PACK       = 4
) (
    input  logic rclk,
    input  logic rrst,
    fifo_rd_packer_if.master bus
);
    localparam int HELD_W = $clog2(PACK + 1);
    localparam logic [HELD_W-1:0] HELD_FULL = HELD_W'(PACK);
    localparam logic [HELD_W-1:0] HELD_LAST = HELD_W'(PACK - 1);

    typedef enum logic {FILL, WAIT_OUT} state_t;

    state_t                             state;
    logic [HELD_W-1:0]                  held;
    logic                               rd_vld;
    logic                               flush_pend;
    logic [PACK-1:0][DATA_WIDTH-1:0]    pack_q;
    logic [PACK-1:0][DATA_WIDTH-1:0]    cap_word;
    logic [PACK-1:0][DATA_WIDTH-1:0]    part_word;
    logic [PACK-1:0]                    part_keep;
    logic [PACK-1:0][DATA_WIDTH-1:0]    m_data_q;
    logic [PACK-1:0]                    m_keep_q;
    logic                               m_last_q;
    logic                               m_valid_q;
    logic                               out_free;
    logic                               pop_ok;
    logic [HELD_W:0]                    occupancy;

    assign out_free  = !m_valid_q || bus.m_ready;
    assign occupancy = {1'b0, held} + (HELD_W+1)'(rd_vld);
    // Second term lets the pop that completes a word overlap its hand-off.
    assign pop_ok    = (occupancy < (HELD_W+1)'(PACK)) ||
                       (rd_vld && held == HELD_LAST && out_free);

    assign bus.fifo_r_en = !rrst && !bus.fifo_empty && !flush_pend &&
                           state == FILL && pop_ok;

    assign bus.m_data  = m_data_q;
    assign bus.m_keep  = m_keep_q;
    assign bus.m_last  = m_last_q;
    assign bus.m_valid = m_valid_q;

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        cap_word  = pack_q;
        part_word = '0;
        part_keep = '0;
        for (int i = 0; i < PACK; i++) begin
            if (rd_vld && held == HELD_W'(i))
                cap_word[i] = bus.fifo_data;
            if (HELD_W'(i) < held) begin
                part_word[i] = pack_q[i];
                part_keep[i] = 1'b1;
            end
        end
    end

    // NOTE: the pack lanes are pure datapath with no reset; held decides which lanes count.
    always_ff @(posedge rclk) begin
        if (rd_vld)
            pack_q <= cap_word;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge rclk or posedge rrst) begin
        if (rrst) begin
            state      <= FILL;
            held       <= '0;
            rd_vld     <= 1'b0;
            flush_pend <= 1'b0;
            m_data_q   <= '0;
            m_keep_q   <= '0;
            m_last_q   <= 1'b0;
            m_valid_q  <= 1'b0;
        end else begin
            rd_vld <= bus.fifo_r_en;
            if (m_valid_q && bus.m_ready)
                m_valid_q <= 1'b0;

            case (state)
                FILL: begin
                    if (rd_vld) begin
                        if (held == HELD_LAST) begin
                            if (out_free) begin
                                m_data_q   <= cap_word;
                                m_keep_q   <= '1;
                                m_last_q   <= flush_pend || bus.flush;
                                m_valid_q  <= 1'b1;
                                held       <= '0;
                                flush_pend <= 1'b0;
                            end else begin
                                held       <= HELD_FULL;
                                state      <= WAIT_OUT;
                                flush_pend <= flush_pend || bus.flush;
                            end
                        end else begin
                            held <= held + HELD_W'(1);
                            if (bus.flush)
                                flush_pend <= 1'b1;
                        end
                    end else if (flush_pend && out_free) begin
                        m_data_q   <= part_word;
                        m_keep_q   <= part_keep;
                        m_last_q   <= 1'b1;
                        m_valid_q  <= 1'b1;
                        held       <= '0;
                        flush_pend <= 1'b0;
                    end else if (bus.flush && held != '0) begin
                        flush_pend <= 1'b1;
                    end
                end

                WAIT_OUT: begin
                    if (out_free) begin
                        m_data_q   <= pack_q;
                        m_keep_q   <= '1;
                        m_last_q   <= flush_pend || bus.flush;
                        m_valid_q  <= 1'b1;
                        held       <= '0;
                        flush_pend <= 1'b0;
                        state      <= FILL;
                    end else if (bus.flush) begin
                        flush_pend <= 1'b1;
                    end
                end

                default: state <= FILL;
            endcase
        end
    end
endmodule

// File: tb/tb_fifo_rd_packer.sv
// Directed bench for fifo_rd_packer: a FIFO model with 1-cycle read latency
// feeds the DUT, and a monitor logs pops and accepted words with cycle stamps.
module tb_fifo_rd_packer;
    localparam int DW = 8;
    localparam int PK = 4;

    logic rclk = 1'b0;
    logic rrst = 1'b1;
    always #5 rclk = ~rclk;

    fifo_rd_packer_if #(.DATA_WIDTH(DW), .PACK(PK)) bus ();

    fifo_rd_packer #(.DATA_WIDTH(DW), .PACK(PK)) dut (
        .rclk (rclk),
        .rrst (rrst),
        .bus  (bus)
    );

    // FIFO model: registered data_out, valid the cycle after a sampled pop.
    logic [7:0] mem [0:511];
    int         wr_ptr   = 0;
    int         rd_ptr   = 0;
    logic       fifo_clr = 1'b0;

    assign bus.fifo_empty = (rd_ptr == wr_ptr);

    always @(posedge rclk) begin
        if (fifo_clr)
            rd_ptr <= wr_ptr;
        else if (bus.fifo_r_en) begin
            bus.fifo_data <= mem[rd_ptr[8:0]];
            rd_ptr        <= rd_ptr + 1;
        end
    end

    // Monitor, sampled mid-cycle.
    int          cyc = 0;
    int          n_words = 0;
    int          n_pops = 0;
    int          pop_cyc [0:511];
    logic [31:0] w_data  [0:127];
    logic [3:0]  w_keep  [0:127];
    logic        w_last  [0:127];
    int          w_cyc   [0:127];
    int          w_np    [0:127];

    always @(posedge rclk) cyc <= cyc + 1;

    always @(negedge rclk) begin
        if (!rrst) begin
            if (bus.m_valid && bus.m_ready) begin
                w_data[n_words] <= bus.m_data;
                w_keep[n_words] <= bus.m_keep;
                w_last[n_words] <= bus.m_last;
                w_cyc[n_words]  <= cyc;
                w_np[n_words]   <= n_pops;
                n_words         <= n_words + 1;
            end
            if (bus.fifo_r_en) begin
                pop_cyc[n_pops] <= cyc;
                n_pops          <= n_pops + 1;
            end
        end
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge rclk);
        #1;
    endtask

    task automatic push(input logic [7:0] b);
        mem[wr_ptr[8:0]] = b;
        wr_ptr++;
    endtask

    task automatic pulse_flush();
        bus.flush = 1'b1;
        tick(1);
        bus.flush = 1'b0;
    endtask

    task automatic wait_words(input string tag, input int target, input int budget);
        int k;
        k = 0;
        while (n_words < target && k < budget) begin
            tick(1);
            k++;
        end
        check(tag, 64'(n_words >= target), 64'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int          base_p;
    int          base_w;
    logic [31:0] exp_word;

    initial begin
        bus.flush   = 1'b0;
        bus.m_ready = 1'b0;

        // Reset state, with a byte available so the pop gate is exercised.
        #2;
        push(8'hEE);
        #1;
        check("rst_m_valid",   64'(bus.m_valid),   64'd0);
        check("rst_m_data",    64'(bus.m_data),    64'd0);
        check("rst_m_keep",    64'(bus.m_keep),    64'd0);
        check("rst_m_last",    64'(bus.m_last),    64'd0);
        check("rst_fifo_r_en", 64'(bus.fifo_r_en), 64'd0);
        fifo_clr = 1'b1;
        tick(1);
        fifo_clr = 1'b0;
        tick(2);
        rrst = 1'b0;
        tick(1);

        // Single word, full throughput.
        base_p = n_pops; base_w = n_words;
        bus.m_ready = 1'b1;
        push(8'h11); push(8'h22); push(8'h33); push(8'h44);
        wait_words("t1_wait", base_w + 1, 30);
        tick(6);
        check("t1_pops",     64'(n_pops - base_p), 64'd4);
        check("t1_pop_span", 64'(pop_cyc[base_p+3] - pop_cyc[base_p]), 64'd3);
        check("t1_latency",  64'(w_cyc[base_w] - pop_cyc[base_p]), 64'd5);
        check("t1_words",    64'(n_words - base_w), 64'd1);
        check("t1_data",     64'(w_data[base_w]), 64'h44332211);
        check("t1_keep",     64'(w_keep[base_w]), 64'hF);
        check("t1_last",     64'(w_last[base_w]), 64'd0);

        // 64-byte stream at one byte per cycle.
        base_p = n_pops; base_w = n_words;
        for (int i = 0; i < 64; i++) push(8'(i));
        wait_words("t2_wait", base_w + 16, 200);
        tick(4);
        check("t2_pops",      64'(n_pops - base_p), 64'd64);
        check("t2_pop_span",  64'(pop_cyc[base_p+63] - pop_cyc[base_p]), 64'd63);
        check("t2_words",     64'(n_words - base_w), 64'd16);
        check("t2_lat_w0",    64'(w_cyc[base_w] - pop_cyc[base_p]), 64'd5);
        check("t2_lat_w15",   64'(w_cyc[base_w+15] - pop_cyc[base_p]), 64'd65);
        for (int w = 0; w < 16; w++) begin
            for (int j = 0; j < 4; j++) exp_word[8*j +: 8] = 8'(4*w + j);
            check($sformatf("t2_word%0d", w), 64'(w_data[base_w+w]), 64'(exp_word));
        end
        check("t2_keep15", 64'(w_keep[base_w+15]), 64'hF);
        check("t2_last15", 64'(w_last[base_w+15]), 64'd0);

        // Backpressure: two words buffered, then released in order.
        bus.m_ready = 1'b0;
        base_p = n_pops; base_w = n_words;
        for (int i = 0; i < 10; i++) push(8'(i));
        tick(20);
        check("t3_pops_stalled", 64'(n_pops - base_p), 64'd8);
        check("t3_valid",        64'(bus.m_valid), 64'd1);
        check("t3_data",         64'(bus.m_data),  64'h03020100);
        tick(3);
        check("t3_data_hold",    64'(bus.m_data),  64'h03020100);
        check("t3_keep_hold",    64'(bus.m_keep),  64'hF);
        bus.m_ready = 1'b1;
        wait_words("t3_wait", base_w + 2, 20);
        tick(6);
        check("t3_word0",   64'(w_data[base_w]),   64'h03020100);
        check("t3_word1",   64'(w_data[base_w+1]), 64'h07060504);
        check("t3_pops_all", 64'(n_pops - base_p), 64'd10);
        check("t3_retained", 64'(n_words - base_w), 64'd2);
        pulse_flush();
        wait_words("t3_flush_wait", base_w + 3, 20);
        check("t3_tail_data", 64'(w_data[base_w+2]), 64'h00000908);
        check("t3_tail_keep", 64'(w_keep[base_w+2]), 64'h3);
        check("t3_tail_last", 64'(w_last[base_w+2]), 64'd1);

        // Partial flush, then a flush with nothing held.
        base_w = n_words;
        push(8'hA1); push(8'hA2); push(8'hA3);
        tick(8);
        check("t4_partial_held", 64'(n_words - base_w), 64'd0);
        pulse_flush();
        wait_words("t4_wait", base_w + 1, 20);
        check("t4_data", 64'(w_data[base_w]), 64'h00A3A2A1);
        check("t4_keep", 64'(w_keep[base_w]), 64'h7);
        check("t4_last", 64'(w_last[base_w]), 64'd1);
        tick(3);
        base_w = n_words;
        pulse_flush();
        tick(8);
        check("t4_idle_flush", 64'(n_words - base_w), 64'd0);

        // Flush in the cycle that pops the second byte.
        base_p = n_pops; base_w = n_words;
        push(8'hB1);
        tick(1);
        push(8'hB2);
        bus.flush = 1'b1;
        #3;
        check("t5_pop_with_flush", 64'(bus.fifo_r_en), 64'd1);
        @(posedge rclk);
        #1;
        bus.flush = 1'b0;
        push(8'hC3);
        wait_words("t5_wait", base_w + 1, 20);
        check("t5_data",       64'(w_data[base_w]), 64'h0000B2B1);
        check("t5_keep",       64'(w_keep[base_w]), 64'h3);
        check("t5_last",       64'(w_last[base_w]), 64'd1);
        check("t5_pops_before", 64'(w_np[base_w] - base_p), 64'd2);
        tick(4);
        pulse_flush();
        wait_words("t5_tail_wait", base_w + 2, 20);
        check("t5_tail_data", 64'(w_data[base_w+1]), 64'h000000C3);
        check("t5_tail_keep", 64'(w_keep[base_w+1]), 64'h1);

        // Asynchronous reset with a stalled word and two bytes held.
        bus.m_ready = 1'b0;
        for (int i = 0; i < 6; i++) push(8'(8'h50 + i));
        tick(14);
        check("t6_stalled", 64'(bus.m_valid), 64'd1);
        #2;
        push(8'h56); push(8'h57);
        rrst = 1'b1;
        #1;
        check("t6_rst_r_en",  64'(bus.fifo_r_en), 64'd0);
        check("t6_rst_valid", 64'(bus.m_valid),   64'd0);
        check("t6_rst_keep",  64'(bus.m_keep),    64'd0);
        check("t6_rst_data",  64'(bus.m_data),    64'd0);
        fifo_clr = 1'b1;
        @(posedge rclk);
        #1;
        fifo_clr = 1'b0;
        tick(1);
        rrst = 1'b0;
        base_w = n_words;
        bus.m_ready = 1'b1;
        push(8'h60); push(8'h61); push(8'h62); push(8'h63);
        wait_words("t6_wait", base_w + 1, 30);
        check("t6_data", 64'(w_data[base_w]), 64'h63626160);
        check("t6_keep", 64'(w_keep[base_w]), 64'hF);
        check("t6_last", 64'(w_last[base_w]), 64'd0);

        tick(2);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/fifo_rd_packer.md
Name: fifo_rd_packer

Overview:
- Read-side drain engine for the team's async FIFO.
- Lives in the read clock domain and pops the FIFO through its r_en/empty/data_out interface, which has a one-cycle registered read latency.
- Packs PACK consecutive bytes into one output word and presents each word on a valid/ready stream.
- A flush request emits a partial word with a lane-keep mask and a last marker.

Parameters:
- DATA_WIDTH, 8, width of one FIFO entry (one lane).
- PACK, 4, lanes per output word; must be at least 2.

Ports:
- rclk  input  1  read-domain clock; all logic on posedge.
- rrst  input  1  reset, asynchronous, active-high.
- fifo_empty  input  1  FIFO empty flag, already synchronous to rclk.
- fifo_r_en  output  1  FIFO pop request (combinational).
- fifo_data  input  DATA_WIDTH  FIFO data_out; valid the cycle after a sampled pop.
- flush  input  1  single-cycle request to emit the partially filled word.
- m_data  output  DATA_WIDTH*PACK  packed word; lane 0 (bits DATA_WIDTH-1:0) holds the oldest byte.
- m_keep  output  PACK  lane-valid mask, contiguous from bit 0.
- m_last  output  1  word was closed by a flush.
- m_valid  output  1  output word valid.
- m_ready  input  1  downstream accepts the word when m_valid && m_ready at the edge.

Behaviour:
- Reset (rrst high, asynchronous):
  - m_valid=0, m_data=0, m_keep=0, m_last=0.
  - held=0, rd_vld=0, flush_pend=0, state=FILL.
  - fifo_r_en is forced to 0 for as long as rrst is high, with no clock needed.
  - Bytes already popped are discarded.
- Internal state:
  - Pack register of PACK lanes.
  - held: 0..PACK.
  - rd_vld: fifo_r_en registered, i.e. one byte in flight.
  - out_free = !m_valid || m_ready.
- Pop rule:
  - fifo_r_en = !rrst && !fifo_empty && !flush_pend && state==FILL && pop_ok.
  - pop_ok = (held+rd_vld < PACK) || (rd_vld && held==PACK-1 && out_free).
  - The second term sustains one pop per cycle.
- Capture: on an edge with rd_vld=1, fifo_data is written to lane[held] and held increments.
- Word completion (the byte captured fills lane PACK-1):
  - If out_free: load m_data/m_keep (all ones)/m_last and set m_valid=1; held becomes 0.
  - Otherwise: held becomes PACK and state goes to WAIT_OUT.
- WAIT_OUT:
  - No pops.
  - At the first edge with out_free, transfer the pack to the output and return to FILL with held=0.
- Flush:
  - Sampled when flush=1. If held==0 and rd_vld==0, the flush is ignored with no output.
  - Otherwise flush_pend is set and pops stop.
  - Once rd_vld==0 and out_free, the word is emitted with held lanes:
    - Unused lanes of m_data are 0.
    - m_keep has the low held bits set.
    - m_last=1.
  - Then held=0 and flush_pend=0.
  - A flush arriving while a full word is pending or completing marks that word m_last=1.
- Output hold: m_data, m_keep and m_last stay stable while m_valid && !m_ready.
- Latency: first pop in cycle 0 at full throughput gives m_valid high in cycle PACK+1.
- Throughput: one byte per cycle, one word per PACK cycles.
- Empty mid-word: pops pause and the partial bytes are retained indefinitely until more data or a flush arrives.
- Ordering: strict FIFO order across words; no byte is dropped or duplicated except on reset.

Test Plan:
- Reset, FIFO holds 0x11,0x22,0x33,0x44, m_ready=1 -> exactly 4 fifo_r_en cycles (0-3); m_valid high in cycle 5 only; m_data=0x44332211, m_keep=4'hF, m_last=0.
- 64 bytes 0x00..0x3F, m_ready=1 -> fifo_r_en high 64 consecutive cycles; 16 words, m_valid in cycles 5,9,...,65; word0=0x03020100, word15=0x3F3E3D3C.
- 10 bytes, m_ready=0 -> pops stop after 8; m_data=0x03020100 held stable and a second word pending; raise m_ready -> words 0x03020100, 0x07060504 in order, then pops resume for bytes 8,9.
- 3 bytes 0xA1,0xA2,0xA3 then flush -> m_data=0x00A3A2A1, m_keep=4'b0111, m_last=1; a flush with held=0 and nothing in flight -> no m_valid.
- Flush in the same cycle fifo_r_en pops the 2nd byte (0xB1,0xB2) -> flush waits for capture; m_data=0x0000B2B1, m_keep=4'b0011, m_last=1; no further pops until emitted.
- rrst asserted mid-cycle with a word stalled at the output and 2 bytes held -> m_valid and fifo_r_en drop immediately without a clock edge; after release, a new 4-byte sequence emits a clean word with m_keep=4'hF.
